// File: rtl/scorer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : scorer
// Brief    : Frame-rate penalty scorer. Folds per-pixel hit strobes into
//            per-frame verdicts and drives a saturating 0-7 score with
//            hold, cooldown and decay behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module scorer #(
    parameter int HOLD_FRAMES     = 30,
    parameter int COOLDOWN_FRAMES = 60,
    parameter int DECAY_FRAMES    = 120
) (
    input  logic       clk_pixel,
    input  logic       rst_in,
    input  logic       new_frame_in,
    input  logic       hit_in,
    input  logic       clear_in,
    output logic [2:0] score_out,
    output logic       score_changed_out,
    output logic       frame_hit_out
);

    localparam int c_STREAK_W = $clog2(HOLD_FRAMES + 1);
    localparam int c_CD_W     = $clog2(COOLDOWN_FRAMES + 1);
    localparam int c_CLEAN_W  = $clog2(DECAY_FRAMES + 1);

    localparam logic [c_STREAK_W-1:0] c_HOLD      = c_STREAK_W'(HOLD_FRAMES);
    localparam logic [c_CD_W-1:0]     c_COOLDOWN  = c_CD_W'(COOLDOWN_FRAMES);
    localparam logic [c_CLEAN_W-1:0]  c_DECAY     = c_CLEAN_W'(DECAY_FRAMES);
    localparam logic [c_STREAK_W-1:0] c_STREAK_1  = c_STREAK_W'(1);
    localparam logic [c_CD_W-1:0]     c_CD_1      = c_CD_W'(1);
    localparam logic [c_CLEAN_W-1:0]  c_CLEAN_1   = c_CLEAN_W'(1);
    localparam logic [2:0]            c_SCORE_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_CLEAN    = 2'd0,
        ST_ACCUM    = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_hl;
    logic [c_STREAK_W-1:0] r_streak;
    logic [c_CD_W-1:0]     r_cd_cnt;
    logic [c_CLEAN_W-1:0]  r_clean_cnt;

    logic [c_STREAK_W-1:0] w_streak_inc;
    logic [c_CD_W-1:0]     w_cd_inc;
    logic [c_CLEAN_W-1:0]  w_clean_inc;

    assign w_streak_inc = r_streak + c_STREAK_1;
    assign w_cd_inc     = r_cd_cnt + c_CD_1;
    assign w_clean_inc  = r_clean_cnt + c_CLEAN_1;

    // The verdict is r_hl alone: a hit landing on the frame-start cycle is
    // loaded into r_hl and therefore belongs to the frame that is starting.
    always_ff @(posedge clk_pixel) begin
        if (rst_in) begin
            r_state           <= ST_CLEAN;
            r_hl              <= 1'b0;
            r_streak          <= '0;
            r_cd_cnt          <= '0;
            r_clean_cnt       <= '0;
            score_out         <= 3'd0;
            score_changed_out <= 1'b0;
            frame_hit_out     <= 1'b0;
        end else begin
            score_changed_out <= 1'b0;
            if (clear_in) begin
                r_state           <= ST_CLEAN;
                r_hl              <= 1'b0;
                r_streak          <= '0;
                r_cd_cnt          <= '0;
                r_clean_cnt       <= '0;
                score_out         <= 3'd0;
                score_changed_out <= (score_out != 3'd0);
            end else if (new_frame_in) begin
                r_hl          <= hit_in;
                frame_hit_out <= r_hl;
                case (r_state)
                    ST_CLEAN: begin
                        if (r_hl) begin
                            r_streak    <= c_STREAK_1;
                            r_clean_cnt <= '0;
                            r_state     <= ST_ACCUM;
                        end else if (w_clean_inc == c_DECAY) begin
                            r_clean_cnt <= '0;
                            if (score_out != 3'd0) begin
                                score_out         <= score_out - 3'd1;
                                score_changed_out <= 1'b1;
                            end
                        end else begin
                            r_clean_cnt <= w_clean_inc;
                        end
                    end
                    ST_ACCUM: begin
                        if (r_hl) begin
                            if (w_streak_inc == c_HOLD) begin
                                if (score_out != c_SCORE_MAX) begin
                                    score_out         <= score_out + 3'd1;
                                    score_changed_out <= 1'b1;
                                end
                                r_streak <= '0;
                                r_cd_cnt <= '0;
                                r_state  <= ST_COOLDOWN;
                            end else begin
                                r_streak <= w_streak_inc;
                            end
                        end else begin
                            // The clean frame that broke the streak counts toward decay.
                            r_streak    <= '0;
                            r_clean_cnt <= c_CLEAN_1;
                            r_state     <= ST_CLEAN;
                        end
                    end
                    ST_COOLDOWN: begin
                        if (w_cd_inc == c_COOLDOWN) begin
                            r_cd_cnt    <= '0;
                            r_clean_cnt <= '0;
                            r_state     <= ST_CLEAN;
                        end else begin
                            r_cd_cnt <= w_cd_inc;
                        end
                    end
                    default: begin
                        r_state <= ST_CLEAN;
                    end
                endcase
            end else if (hit_in) begin
                r_hl <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/scorer.md
# scorer

Frame-rate penalty scorer producing the 3-bit `score` consumed by the score sprite/video mux. Accumulates per-pixel hit (violation) strobes into per-frame verdicts, increments a saturating 0–7 score after a sustained run of hit frames, applies a cooldown, and decays the score after long clean runs. Sits between the pixel-domain detection logic and the score display, clocked on the pixel clock.

## Interface
Parameters:
- `HOLD_FRAMES`, 30: consecutive hit frames required per increment (legal 2–255).
- `COOLDOWN_FRAMES`, 60: frames ignored after an increment (legal 1–255).
- `DECAY_FRAMES`, 120: consecutive clean frames per decrement (legal 1–1023).

Ports:
- `clk_pixel` in 1: pixel clock; the only clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `new_frame_in` in 1: single-cycle pulse marking frame start.
- `hit_in` in 1: per-pixel violation strobe, any cycle.
- `clear_in` in 1: synchronous score clear.
- `score_out` out 3: current score, registered.
- `score_changed_out` out 1: single-cycle pulse when `score_out` changes value.
- `frame_hit_out` out 1: verdict of the most recently completed frame, registered.

## Operation
- Hit latch `hl`: set by any cycle with `hit_in`=1. On a `new_frame_in` cycle, the current `hl` OR'ed with `hit_in` is *not* used. Instead, verdict V = `hl` (excluding that cycle's `hit_in`). `hl` is then loaded with that cycle's `hit_in`, so a hit coincident with `new_frame_in` belongs to the new frame.
- On every `new_frame_in`, the FSM evaluates V. Counters are frame counts with minimal widths: `streak`, `cd_cnt`, and `clean_cnt`.
- CLEAN:
  - V=1: `streak`←1, `clean_cnt`←0, go to ACCUM.
  - V=0: `clean_cnt`+1. On reaching DECAY_FRAMES, `clean_cnt`←0 and score decrements if it is nonzero.
- ACCUM:
  - V=1: `streak`+1. On reaching HOLD_FRAMES, score increments (saturating at 7), `streak`←0, `cd_cnt`←0, go to COOLDOWN.
  - V=0: `streak`←0, `clean_cnt`←1, go to CLEAN.
- COOLDOWN:
  - V is ignored for scoring. `cd_cnt`+1; on reaching COOLDOWN_FRAMES, `cd_cnt`←0, `clean_cnt`←0, go to CLEAN.
- Saturation at 7 and decrement at 0 leave the score unchanged; no `score_changed_out` pulse is generated.
- `clear_in` clears the score to 0, enters CLEAN, and zeroes all counters and `hl`. It has priority over `new_frame_in` and `hit_in` in the same cycle; that frame's verdict is discarded. `score_changed_out` pulses only if the score was nonzero.
- `rst_in` has priority over everything.
  - Reset state: `score_out`=0, `score_changed_out`=0, `frame_hit_out`=0, CLEAN, all counters 0, `hl`=0.
  - Reset mid-frame discards the partial frame.
- `new_frame_in` held high across consecutive cycles: each high cycle is a frame boundary. The driver must not do this; the behaviour is defined only for verification.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `new_frame_in` at cycle t: `frame_hit_out`, `score_out`, and `score_changed_out` reflect the evaluation at t+1.
- `score_changed_out` is high for exactly one cycle, coincident with the first cycle of the new `score_out` value.
- `clear_in` at cycle t: `score_out`=0 at t+1.
- `hit_in` is sampled every cycle and has no minimum width.
- The maximum event rate is one score change per frame.

## Test plan
Bench parameters: HOLD_FRAMES=4, COOLDOWN_FRAMES=2, DECAY_FRAMES=8. Frames are 100 cycles long.
- **Reset:** assert `rst_in` 3 cycles with random `hit_in` → `score_out`=0, `score_changed_out`=0, `frame_hit_out`=0. The first frame after release scores from zero.
- **Increment:** one `hit_in` pulse mid-frame in each of 4 consecutive frames → one cycle after the 4th closing `new_frame_in`: `score_out`=1, `score_changed_out`=1 for 1 cycle.
  - Hits in the next 2 frames (cooldown) → no change.
- **Broken streak:** 3 hit frames, 1 clean frame, 3 hit frames → `score_out` stays 0.
  - `hit_in` only on the `new_frame_in` cycle of frame N → frame N-1 verdict=0, frame N verdict=1.
- **Saturation:** reach 7, then 4 more hit frames after cooldown → `score_out`=7 with no `score_changed_out` pulse.
- **Decay:** from `score_out`=2, 8 clean frames after cooldown expiry → 1; 8 more → 0; 8 more → stays 0 with no pulse.
- **Clear collision:** with score=3, assert `clear_in` and `new_frame_in` in the same cycle, with a hit during the frame → next cycle `score_out`=0, pulse=1, state CLEAN.
  - A following hit-frame streak needs a full 4 frames to reach 1.
